// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// latched request record, legality and misalignment checks.
package lsu_pkg;
    localparam int DM_ADDRESS = 9;
    localparam int DATA_W     = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} lsu_state_t;

    typedef struct packed {
        logic                  we;
        logic [DM_ADDRESS-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [2:0]            funct3;
    } lsu_req_t;

    // funct3[1:0] encodes the access size for every legal code
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return |lo;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return {lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return lo;
        endcase
    endfunction
endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus interfaces of the LSU.
interface lsu_core_if;
    import lsu_pkg::*;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (output req_valid, req_we, req_addr, req_wdata, req_funct3,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_funct3,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

interface lsu_mem_if;
    import lsu_pkg::*;
    logic                  mem_req;
    logic                  mem_we;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and load
// byte/halfword selection with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [1:0]        lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_ext
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        b          = rdata[{lo, 3'b000} +: 8];
        h          = rdata[{lo[1], 4'b0000} +: 16];
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = funct3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                be         = 4'b0011 << {lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            end
            default: ;
        endcase
        // loads always fetch the full word
        if (!we) be = 4'b1111;
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between execute stage and data memory.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses error out instead of being aligned down.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);
    lsu_state_t        state, state_n;
    lsu_req_t          r;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              acc_err;
    logic [1:0]        eff_lo;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata_lane, rdata_ext;
    logic              in_req;

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        acc_err = !is_legal(core.req_we, core.req_funct3) ||
                  is_misaligned(core.req_funct3, core.req_addr[1:0]);
        eff_lo  = core.req_addr[1:0];
`else
        acc_err = !is_legal(core.req_we, core.req_funct3);
        eff_lo  = align_lo(core.req_funct3, core.req_addr[1:0]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (core.req_valid) state_n = acc_err ? RESP : REQ;
            REQ:     if (mem.mem_gnt)    state_n = r.we ? RESP : WAIT_R;
            WAIT_R:  if (mem.mem_rvalid) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (state == IDLE && core.req_valid) begin
            r       <= '{we: core.req_we, addr: {core.req_addr[DM_ADDRESS-1:2], eff_lo},
                         wdata: core.req_wdata, funct3: core.req_funct3};
            err_q   <= acc_err;
            rdata_q <= '0;
        end else if (state == WAIT_R && mem.mem_rvalid) begin
            rdata_q <= rdata_ext;
        end
    end

    lsu_lane_align u_align (
        .we         (r.we),
        .funct3     (r.funct3),
        .lo         (r.addr[1:0]),
        .wdata      (r.wdata),
        .rdata      (mem.mem_rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // bus outputs decode from state so reset drops them without a clock edge
    assign in_req          = (state == REQ);
    assign mem.mem_req     = in_req;
    assign mem.mem_we      = in_req & r.we;
    assign mem.mem_addr    = in_req ? {r.addr[DM_ADDRESS-1:2], 2'b00} : '0;
    assign mem.mem_be      = in_req ? be : 4'b0000;
    assign mem.mem_wdata   = in_req ? wdata_lane : '0;

    assign core.req_ready  = (state == IDLE);
    assign core.resp_valid = (state == RESP);
    assign core.resp_rdata = rdata_q;
    assign core.resp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random accesses against an arithmetic model of the LSU rules.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_core_if core ();
    lsu_mem_if  mem ();

    load_store_unit dut (.clk(clk), .rst_n(rst_n), .core(core.slave), .mem(mem.master));

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [8:0] addr, input logic [2:0] f3,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output logic err, output logic [8:0] waddr,
                                  output logic [3:0] be, output logic [31:0] wexp,
                                  output logic [31:0] rexp);
        int nb, off, a, ea;
        logic legal, mis;
        logic [31:0] mask, v;
        nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        a = addr;
        mis = (a % nb) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        err = !legal || mis;
        ea = a;
`else
        err = !legal;
        ea = a - (a % nb);
`endif
        off = ea % 4;
        waddr = 9'(ea - off);
        be = we ? 4'(((1 << nb) - 1) << off) : 4'hF;
        wexp = (nb == 1) ? wd[7:0] * 32'h01010101 : (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
        mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
        v = (rd >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        rexp = (err || we) ? 32'h0 : v;
    endfunction

    task automatic access(input string tag, input logic we, input logic [8:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input int gd, input int rdly, input logic [31:0] rd);
        logic err; logic [8:0] waddr; logic [3:0] be; logic [31:0] wexp, rexp;
        model(we, addr, f3, wd, rd, err, waddr, be, wexp, rexp);
        @(negedge clk);
        check({tag, " ready"}, core.req_ready, 1'b1);
        core.req_valid = 1'b1; core.req_we = we; core.req_addr = addr;
        core.req_wdata = wd; core.req_funct3 = f3;
        @(posedge clk); #1;
        core.req_valid = 1'b0;
        check({tag, " busy"}, core.req_ready, 1'b0);
        if (err) begin
            check({tag, " err_valid"}, core.resp_valid, 1'b1);
            check({tag, " err_flag"}, core.resp_err, 1'b1);
            check({tag, " err_rdata"}, core.resp_rdata, 32'h0);
            check({tag, " err_nomem"}, mem.mem_req, 1'b0);
        end else begin
            for (int i = 0; i < gd; i++) begin
                check({tag, " req_hold"}, mem.mem_req, 1'b1);
                @(posedge clk); #1;
            end
            check({tag, " mem_req"}, mem.mem_req, 1'b1);
            check({tag, " mem_we"}, mem.mem_we, we);
            check({tag, " mem_addr"}, mem.mem_addr, waddr);
            check({tag, " mem_be"}, mem.mem_be, be);
            if (we) check({tag, " mem_wdata"}, mem.mem_wdata, wexp);
            mem.mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem.mem_gnt = 1'b0;
            if (!we) begin
                check({tag, " wait_noreq"}, mem.mem_req, 1'b0);
                for (int i = 0; i < rdly; i++) begin
                    check({tag, " wait_nores"}, core.resp_valid, 1'b0);
                    mem.mem_rdata = $urandom;
                    @(posedge clk); #1;
                end
                mem.mem_rvalid = 1'b1; mem.mem_rdata = rd;
                @(posedge clk); #1;
                mem.mem_rvalid = 1'b0;
            end
            check({tag, " resp_valid"}, core.resp_valid, 1'b1);
            check({tag, " resp_err"}, core.resp_err, 1'b0);
            check({tag, " resp_rdata"}, core.resp_rdata, rexp);
        end
        @(posedge clk); #1;
        check({tag, " resp_pulse"}, core.resp_valid, 1'b0);
        check({tag, " idle"}, core.req_ready, 1'b1);
    endtask

    initial begin
        core.req_valid = 1'b0; core.req_we = 1'b0; core.req_addr = '0;
        core.req_wdata = '0; core.req_funct3 = '0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        #12;
        check("rst req_ready", core.req_ready, 1'b1);
        check("rst resp_valid", core.resp_valid, 1'b0);
        check("rst resp_rdata", core.resp_rdata, 32'h0);
        check("rst resp_err", core.resp_err, 1'b0);
        check("rst mem_req", mem.mem_req, 1'b0);
        check("rst mem_we", mem.mem_we, 1'b0);
        check("rst mem_addr", mem.mem_addr, 32'h0);
        check("rst mem_be", mem.mem_be, 32'h0);
        check("rst mem_wdata", mem.mem_wdata, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        access("sb", 1'b1, 9'h00D, 32'h0000_00A5, F3_B, 0, 0, 32'h0);
        access("lb", 1'b0, 9'h012, 32'h0, F3_B, 0, 0, 32'h11F0_2233);
        access("lbu", 1'b0, 9'h012, 32'h0, F3_BU, 0, 0, 32'h11F0_2233);
        access("lh", 1'b0, 9'h006, 32'h0, F3_H, 0, 0, 32'h8001_7FFF);
        access("lh_gnt3", 1'b0, 9'h006, 32'h0, F3_H, 3, 0, 32'h8001_7FFF);
        access("lhu", 1'b0, 9'h004, 32'h0, F3_HU, 1, 2, 32'h1234_8765);
        access("lw_mis", 1'b0, 9'h005, 32'h0, F3_W, 0, 1, 32'hDEAD_BEEF);
        access("sh", 1'b1, 9'h00E, 32'hCAFE_BEEF, F3_H, 2, 0, 32'h0);
        access("sw", 1'b1, 9'h100, 32'h0BAD_F00D, F3_W, 0, 0, 32'h0);
        access("ld_f3_011", 1'b0, 9'h020, 32'h0, 3'b011, 0, 0, 32'h0);
        access("st_f3_100", 1'b1, 9'h020, 32'h1, 3'b100, 0, 0, 32'h0);

        // reset while REQ is waiting for grant: mem_req must drop without a clock
        @(negedge clk);
        core.req_valid = 1'b1; core.req_we = 1'b1; core.req_addr = 9'h040;
        core.req_wdata = 32'h5555_AAAA; core.req_funct3 = F3_W;
        @(posedge clk); #1; core.req_valid = 1'b0;
        check("rstreq pre", mem.mem_req, 1'b1);
        #2 rst_n = 1'b0; #1;
        check("rstreq mem_req", mem.mem_req, 1'b0);
        check("rstreq ready", core.req_ready, 1'b1);
        @(negedge clk); rst_n = 1'b1;

        // reset during WAIT_R, then a stale rvalid must be ignored
        @(negedge clk);
        core.req_valid = 1'b1; core.req_we = 1'b0; core.req_addr = 9'h010;
        core.req_funct3 = F3_W;
        @(posedge clk); #1; core.req_valid = 1'b0; mem.mem_gnt = 1'b1;
        @(posedge clk); #1; mem.mem_gnt = 1'b0;
        #2 rst_n = 1'b0; #1;
        check("rstwait mem_req", mem.mem_req, 1'b0);
        check("rstwait ready", core.req_ready, 1'b1);
        check("rstwait resp", core.resp_valid, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h7777_7777;
        @(posedge clk); #1; mem.mem_rvalid = 1'b0;
        check("late_rvalid resp0", core.resp_valid, 1'b0);
        @(posedge clk); #1;
        check("late_rvalid resp1", core.resp_valid, 1'b0);
        check("late_rvalid ready", core.req_ready, 1'b1);
        access("sw_after_rst", 1'b1, 9'h1FC, 32'h1357_9BDF, F3_W, 0, 0, 32'h0);

        for (int n = 0; n < 60; n++) begin
            access("rand", 1'($urandom), 9'($urandom), $urandom, 3'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
